// File: rtl/linear_net_seq_pkg.sv
// Shared types and helpers for the time-multiplexed 3-layer linear network.
// Saturation runs on a 64-bit signed view, so the accumulator must stay within 64 bits (WIDTH <= 30).
package linear_net_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [1:0] layer_t;

    localparam int ACC_GUARD = 4;
    localparam int SAT_W     = 64;

    // Product width plus guard bits so a full row sum can never wrap.
    function automatic int acc_width(input int width);
        return 2 * width + ACC_GUARD;
    endfunction

    function automatic int max_dim(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                     input int width);
        logic signed [SAT_W-1:0] hi, lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/linear_net_seq_if.sv
// Vector-in / vector-out valid/ready bus for linear_net_seq.
interface linear_net_seq_if #(
    parameter int WIDTH = 16,
    parameter int NIN   = 4,
    parameter int NOUT  = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH*NIN-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH*NOUT-1:0]   out_data;
    logic                    busy;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, busy);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/linear_net_seq_mac_unit.sv
// Shared signed MAC: wide accumulator plus saturated view of the next sum.
module lin_mac_unit
    import linear_net_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    accumulate,
    input  logic signed [WIDTH-1:0] weight,
    input  logic signed [WIDTH-1:0] data,
    output logic signed [WIDTH-1:0] result
);
    localparam int ACC_W = acc_width(WIDTH);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc, acc_next;
    logic signed [SAT_W-1:0]   wide;

    always_comb begin
        prod     = weight * data;
        acc_next = acc + ACC_W'(prod);
        wide     = SAT_W'(acc_next);
        result   = WIDTH'(sat(wide, WIDTH));
    end

    // Clear wins so the row-final edge both consumes acc_next and restarts the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          acc <= '0;
        else if (clear)      acc <= '0;
        else if (accumulate) acc <= acc_next;
    end

endmodule

// File: rtl/linear_net_seq.sv
// Sequential NIN->NOUT1->NOUT2->NOUT linear network: one MAC per cycle walking every weight,
// with two ping-pong activation buffers swapping roles at each layer boundary.
module linear_net_seq
    import linear_net_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NIN   = 4,
    parameter int NOUT1 = 3,
    parameter int NOUT2 = 3,
    parameter int NOUT  = 2,
    parameter logic [WIDTH*NIN*NOUT1-1:0]   WEIGHTS_MATRIX_FLAT1 = '0,
    parameter logic [WIDTH*NOUT1*NOUT2-1:0] WEIGHTS_MATRIX_FLAT2 = '0,
    parameter logic [WIDTH*NOUT2*NOUT-1:0]  WEIGHTS_MATRIX_FLAT3 = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    linear_net_seq_if.slave  bus
);
    localparam int MAXDIM = max_dim(NIN, NOUT1, NOUT2);
    // The last layer writes NOUT rows, so the buffers must also cover NOUT.
    localparam int BUF_D  = max_dim(MAXDIM, NOUT, 1);
    localparam int CNT_W  = $clog2(BUF_D + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    state_t state, state_d;
    layer_t layer;
    cnt_t   row, col, nrows, ncols;
    logic   sel;  // 0: buf_a is the source of the current layer

    logic [BUF_D-1:0][WIDTH-1:0] buf_a, buf_b, src_buf;
    logic signed [WIDTH-1:0]     weight, src_val, mac_res;
    logic                        accept, run, col_last, row_last, layer_last;

    always_comb begin
        accept     = (state == IDLE) && bus.in_valid;
        run        = (state == RUN);
        src_buf    = sel ? buf_b : buf_a;
        nrows      = cnt_t'(NOUT);
        ncols      = cnt_t'(NOUT2);
        case (layer)
            2'd0: begin nrows = cnt_t'(NOUT1); ncols = cnt_t'(NIN);   end
            2'd1: begin nrows = cnt_t'(NOUT2); ncols = cnt_t'(NOUT1); end
            default: ;
        endcase
        col_last   = (col == ncols - cnt_t'(1));
        row_last   = (row == nrows - cnt_t'(1));
        layer_last = (layer == 2'd2);
    end

    always_comb begin
        src_val = '0;
        for (int k = 0; k < BUF_D; k++)
            if (col == cnt_t'(k)) src_val = $signed(src_buf[k]);
    end

    // Weight ROM: element [i][j] sits MSB-first in the flat parameter.
    always_comb begin
        weight = '0;
        case (layer)
            2'd0:
                for (int i = 0; i < NOUT1; i++)
                    for (int j = 0; j < NIN; j++)
                        if (row == cnt_t'(i) && col == cnt_t'(j))
                            weight = $signed(WEIGHTS_MATRIX_FLAT1[(NIN*NOUT1-(i*NIN+j))*WIDTH-1 -: WIDTH]);
            2'd1:
                for (int i = 0; i < NOUT2; i++)
                    for (int j = 0; j < NOUT1; j++)
                        if (row == cnt_t'(i) && col == cnt_t'(j))
                            weight = $signed(WEIGHTS_MATRIX_FLAT2[(NOUT1*NOUT2-(i*NOUT1+j))*WIDTH-1 -: WIDTH]);
            2'd2:
                for (int i = 0; i < NOUT; i++)
                    for (int j = 0; j < NOUT2; j++)
                        if (row == cnt_t'(i) && col == cnt_t'(j))
                            weight = $signed(WEIGHTS_MATRIX_FLAT3[(NOUT2*NOUT-(i*NOUT2+j))*WIDTH-1 -: WIDTH]);
            default: ;
        endcase
    end

    lin_mac_unit #(.WIDTH(WIDTH)) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept || (run && col_last)),
        .accumulate (run),
        .weight     (weight),
        .data       (src_val),
        .result     (mac_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d       = state;
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.out_data  = '0;
        case (state)
            IDLE: if (bus.in_valid) state_d = RUN;
            RUN:  if (col_last && row_last && layer_last) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // After three swaps the final layer's results sit in the current source buffer.
        if (state == DONE)
            for (int k = 0; k < NOUT; k++)
                bus.out_data[k*WIDTH +: WIDTH] = src_buf[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer <= '0;
            row   <= '0;
            col   <= '0;
            sel   <= 1'b0;
            buf_a <= '0;
            buf_b <= '0;
        end else if (accept) begin
            for (int k = 0; k < NIN; k++)
                buf_a[k] <= bus.in_data[k*WIDTH +: WIDTH];
            layer <= '0;
            row   <= '0;
            col   <= '0;
            sel   <= 1'b0;
        end else if (run) begin
            if (col_last) begin
                col <= '0;
                for (int k = 0; k < BUF_D; k++)
                    if (row == cnt_t'(k)) begin
                        if (sel) buf_a[k] <= mac_res;
                        else     buf_b[k] <= mac_res;
                    end
                if (row_last) begin
                    row   <= '0;
                    layer <= layer + 2'd1;
                    sel   <= ~sel;
                end else begin
                    row <= row + cnt_t'(1);
                end
            end else begin
                col <= col + cnt_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_linear_net_seq.sv
// Directed bench for linear_net_seq: three instances with identity, mixed and saturating weights.
module tb_linear_net_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [191:0] ID_W1 = {16'sd1, 16'sd0, 16'sd0, 16'sd0,
                                      16'sd0, 16'sd1, 16'sd0, 16'sd0,
                                      16'sd0, 16'sd0, 16'sd1, 16'sd0};
    localparam logic [143:0] ID_W2 = {16'sd1, 16'sd0, 16'sd0,
                                      16'sd0, 16'sd1, 16'sd0,
                                      16'sd0, 16'sd0, 16'sd1};
    localparam logic [95:0]  ID_W3 = {16'sd1, 16'sd0, 16'sd0,
                                      16'sd0, 16'sd1, 16'sd0};
    localparam logic [191:0] MX_W1 = {16'sd30, 16'sd780, -16'sd25, -16'sd77,
                                      16'sd308, -16'sd78, -16'sd250, -16'sd779,
                                      -16'sd302, 16'sd788, -16'sd250, -16'sd77};
    localparam logic [143:0] MX_W2 = {16'sd30, 16'sd780, -16'sd25,
                                      16'sd308, -16'sd78, -16'sd250,
                                      -16'sd302, 16'sd788, -16'sd250};
    localparam logic [95:0]  MX_W3 = {16'sd30, 16'sd780, -16'sd25,
                                      16'sd308, -16'sd78, -16'sd250};
    localparam logic [191:0] ST_W1 = {16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000,
                                      16'sd0, 16'sd0, 16'sd0, 16'sd0,
                                      16'sd0, 16'sd0, 16'sd0, 16'sd0};

    logic        iv[3], ordy[3], irdy[3], ov[3], bsy[3];
    logic [63:0] idat[3];
    logic [31:0] odat[3];

    linear_net_seq_if #(.WIDTH(16), .NIN(4), .NOUT(2)) if_id ();
    linear_net_seq_if #(.WIDTH(16), .NIN(4), .NOUT(2)) if_mx ();
    linear_net_seq_if #(.WIDTH(16), .NIN(4), .NOUT(2)) if_st ();

    assign if_id.in_valid = iv[0];  assign if_id.in_data = idat[0];  assign if_id.out_ready = ordy[0];
    assign if_mx.in_valid = iv[1];  assign if_mx.in_data = idat[1];  assign if_mx.out_ready = ordy[1];
    assign if_st.in_valid = iv[2];  assign if_st.in_data = idat[2];  assign if_st.out_ready = ordy[2];
    assign irdy[0] = if_id.in_ready;  assign ov[0] = if_id.out_valid;  assign odat[0] = if_id.out_data;  assign bsy[0] = if_id.busy;
    assign irdy[1] = if_mx.in_ready;  assign ov[1] = if_mx.out_valid;  assign odat[1] = if_mx.out_data;  assign bsy[1] = if_mx.busy;
    assign irdy[2] = if_st.in_ready;  assign ov[2] = if_st.out_valid;  assign odat[2] = if_st.out_data;  assign bsy[2] = if_st.busy;

    linear_net_seq #(.WEIGHTS_MATRIX_FLAT1(ID_W1), .WEIGHTS_MATRIX_FLAT2(ID_W2),
                     .WEIGHTS_MATRIX_FLAT3(ID_W3)) u_id (.clk(clk), .rst_n(rst_n), .bus(if_id));
    linear_net_seq #(.WEIGHTS_MATRIX_FLAT1(MX_W1), .WEIGHTS_MATRIX_FLAT2(MX_W2),
                     .WEIGHTS_MATRIX_FLAT3(MX_W3)) u_mx (.clk(clk), .rst_n(rst_n), .bus(if_mx));
    linear_net_seq #(.WEIGHTS_MATRIX_FLAT1(ST_W1), .WEIGHTS_MATRIX_FLAT2(ID_W2),
                     .WEIGHTS_MATRIX_FLAT3(ID_W3)) u_st (.clk(clk), .rst_n(rst_n), .bus(if_st));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int e);
        return {16'(e), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic int el(input int d, input int k);
        logic [31:0] o;
        o = odat[d];
        return int'($signed(o[k*16 +: 16]));
    endfunction

    // Returns just after the accepting edge.
    task automatic start(input int d, input logic [63:0] v);
        int n;
        n = 0;
        iv[d] = 1'b1;
        idat[d] = v;
        @(negedge clk);
        while (!irdy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!irdy[d]) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 iv[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ov[d] && lat < 200);
        if (!ov[d]) chk("out_timeout", 0, 1);
    endtask

    task automatic run_vec(input int d, input logic [63:0] v, output int o0, output int o1, output int lat);
        ordy[d] = 1'b1;
        start(d, v);
        wait_out(d, lat);
        o0 = el(d, 0);
        o1 = el(d, 1);
        @(posedge clk);
        #1;
    endtask

    int lat, o0, o1, s0, s1, stable;
    int t[3], r0[3], r1[3];
    logic [63:0] sv[3];
    int e0[3] = '{-200, 1, -32768};
    int e1[3] = '{35, 2, 32767};

    initial begin
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; idat[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_in_ready%0d", d), int'(irdy[d]), 1);
            chk($sformatf("rst_out_valid%0d", d), int'(ov[d]), 0);
            chk($sformatf("rst_busy%0d", d), int'(bsy[d]), 0);
            chk($sformatf("rst_out_data%0d", d), int'(odat[d]), 0);
        end
        rst_n = 1'b1;

        // identity path and latency
        run_vec(0, pk(-200, 35, 77, -256), o0, o1, lat);
        chk("id_latency", lat, 27);
        chk("id_out0", o0, -200);
        chk("id_out1", o1, 35);
        @(negedge clk);
        chk("id_post_valid", int'(ov[0]), 0);
        chk("id_post_ready", int'(irdy[0]), 1);
        chk("id_post_busy", int'(bsy[0]), 0);

        // mixed weights with saturation in every layer
        run_vec(1, pk(-200, 35, 77, -256), o0, o1, lat);
        chk("mix_latency", lat, 27);
        chk("mix_out0", o0, -32768);
        chk("mix_out1", o1, 32767);

        // positive / negative clamp
        run_vec(2, pk(1000, 1000, 1000, 1000), o0, o1, lat);
        chk("sat_pos_out0", o0, 32767);
        chk("sat_pos_out1", o1, 0);
        run_vec(2, pk(-1000, -1000, -1000, -1000), o0, o1, lat);
        chk("sat_neg_out0", o0, -32768);
        chk("sat_neg_out1", o1, 0);

        // stall in DONE, stray in_valid during RUN
        ordy[0] = 1'b0;
        start(0, pk(-200, 35, 77, -256));
        repeat (3) @(posedge clk);
        #1 iv[0] = 1'b1;
        idat[0] = pk(5, 6, 7, 8);
        @(negedge clk);
        chk("run_in_ready", int'(irdy[0]), 0);
        chk("run_busy", int'(bsy[0]), 1);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        wait_out(0, lat);
        s0 = el(0, 0);
        s1 = el(0, 1);
        stable = 1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (!ov[0] || el(0, 0) != s0 || el(0, 1) != s1) stable = 0;
        end
        chk("stall_hold", stable, 1);
        chk("stall_out0", s0, -200);
        chk("stall_out1", s1, 35);
        ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_release", int'(ov[0]), 0);

        // reset mid-RUN
        start(0, pk(1, 2, 3, 4));
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(ov[0]), 0);
        chk("mid_rst_ready", int'(irdy[0]), 1);
        chk("mid_rst_busy", int'(bsy[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(irdy[0]), 1);
        chk("post_rst_busy", int'(bsy[0]), 0);
        run_vec(0, pk(-200, 35, 77, -256), o0, o1, lat);
        chk("post_rst_latency", lat, 27);
        chk("post_rst_out0", o0, -200);
        chk("post_rst_out1", o1, 35);

        // streaming, three vectors back to back
        begin
            int ii, oi, n;
            logic acc;
            sv[0] = pk(-200, 35, 77, -256);
            sv[1] = pk(1, 2, 3, 4);
            sv[2] = pk(-32768, 32767, 0, 5);
            ii = 0; oi = 0; n = 0;
            ordy[0] = 1'b1;
            iv[0] = 1'b1;
            idat[0] = sv[0];
            while (oi < 3 && n < 200) begin
                @(negedge clk);
                if (ov[0]) begin
                    t[oi] = cyc; r0[oi] = el(0, 0); r1[oi] = el(0, 1);
                    oi++;
                end
                acc = irdy[0] && iv[0];
                @(posedge clk);
                #1;
                if (acc) begin
                    ii++;
                    if (ii < 3) idat[0] = sv[ii];
                    else iv[0] = 1'b0;
                end
                n++;
            end
            chk("stream_count", oi, 3);
            if (oi == 3) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("stream%0d_out0", k), r0[k], e0[k]);
                    chk($sformatf("stream%0d_out1", k), r1[k], e1[k]);
                end
                chk("stream_gap01", t[1] - t[0], 29);
                chk("stream_gap12", t[2] - t[1], 29);
            end
            iv[0] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
